// File: rtl/zigzag_block_sequencer.sv
// Sequences eight row writes into the 64x8 zigzag buffer, fires the reorder,
// captures the zigzag block and hands it downstream over valid/ready.
module zigzag_block_sequencer #(
  parameter int ZZ_LATENCY  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   s_row_valid,
  input  logic [63:0]            s_row_data,
  output logic                   s_row_ready,
  output logic [7:0]             buf_matrix_row,
  output logic [63:0]            buf_row_data,
  output logic                   buf_input_data_enable,
  output logic                   buf_zigzag_enable,
  input  logic [511:0]           buf_zigzag_in,
  output logic                   m_block_valid,
  output logic [511:0]           m_block_data,
  input  logic                   m_block_ready,
  output logic [COUNT_WIDTH-1:0] block_count,
  output logic                   busy
);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, OUT} state_t;

  localparam logic [3:0] LAT = 4'(ZZ_LATENCY);

  state_t                 state_q;
  logic [2:0]             row_cnt_q;
  logic [3:0]             wait_cnt_q;
  logic [2:0]             row_idx_q;
  logic [63:0]            row_data_q;
  logic                   wr_en_q;
  logic                   zz_en_q;
  logic                   m_valid_q;
  logic [511:0]           m_data_q;
  logic [COUNT_WIDTH-1:0] blk_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL;
      row_cnt_q  <= '0;
      wait_cnt_q <= '0;
      row_idx_q  <= '0;
      row_data_q <= '0;
      wr_en_q    <= 1'b0;
      zz_en_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      blk_cnt_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      zz_en_q <= 1'b0;
      if (flush) begin
        // an output handshake coinciding with flush still counts
        if (m_valid_q && m_block_ready) blk_cnt_q <= blk_cnt_q + COUNT_WIDTH'(1);
        state_q    <= FILL;
        row_cnt_q  <= '0;
        wait_cnt_q <= '0;
        m_valid_q  <= 1'b0;
      end else begin
        case (state_q)
          FILL: if (s_row_valid) begin
            wr_en_q    <= 1'b1;
            row_idx_q  <= row_cnt_q;
            row_data_q <= s_row_data;
            row_cnt_q  <= row_cnt_q + 3'd1;
            if (row_cnt_q == 3'd7) state_q <= ISSUE;
          end
          // first ISSUE cycle overlaps the row-7 write; strobe goes out on the second
          ISSUE: if (!zz_en_q) begin
            zz_en_q <= 1'b1;
          end else begin
            state_q    <= WAIT;
            wait_cnt_q <= LAT;
          end
          WAIT: begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
            if (wait_cnt_q == 4'd1) begin
              m_data_q  <= buf_zigzag_in;
              m_valid_q <= 1'b1;
              state_q   <= OUT;
            end
          end
          OUT: if (m_block_ready) begin
            m_valid_q <= 1'b0;
            blk_cnt_q <= blk_cnt_q + COUNT_WIDTH'(1);
            state_q   <= FILL;
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  assign s_row_ready           = ~reset & (state_q == FILL);
  assign busy                  = ~((state_q == FILL) && (row_cnt_q == 3'd0));
  assign buf_matrix_row        = reset ? 8'd0  : {5'd0, row_idx_q};
  assign buf_row_data          = reset ? 64'd0 : row_data_q;
  assign buf_input_data_enable = wr_en_q & ~reset;
  assign buf_zigzag_enable     = zz_en_q & ~reset;
  assign m_block_valid         = m_valid_q & ~reset;
  assign m_block_data          = m_data_q;
  assign block_count           = blk_cnt_q;

endmodule
